// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter: two line buffers, a 3x3 window register and a
// pipelined compare network. Optional macro MEDIAN_RANK_SELECT_EN adds a rank port.
module median_filter_stream #(
  parameter int DATA_W = 8,
  parameter int WID_W  = 9,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WID_W-1:0]  wid,
  input  logic [LEN_W-1:0]  len,
`ifdef MEDIAN_RANK_SELECT_EN
  input  logic [1:0]        rank,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic [2:0]        s
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef logic [8:0][DATA_W-1:0] pix9_t;
  localparam int DEPTH = 1 << WID_W;

  function automatic pix9_t cs(input pix9_t p, input logic [3:0] a, input logic [3:0] b);
    pix9_t r;
    logic [DATA_W-1:0] t;
    r = p;
    if (r[a] > r[b]) begin
      t    = r[a];
      r[a] = r[b];
      r[b] = t;
    end else begin
      t = r[a];
    end
    return r;
  endfunction

  // Window columns shift left; the new column enters at index 2/5/8 (top..bottom).
  function automatic pix9_t shift_in(input pix9_t w, input logic [DATA_W-1:0] top,
                                     input logic [DATA_W-1:0] mid, input logic [DATA_W-1:0] bot);
    pix9_t r;
    r[0] = w[1]; r[1] = w[2]; r[2] = top;
    r[3] = w[4]; r[4] = w[5]; r[5] = mid;
    r[6] = w[7]; r[7] = w[8]; r[8] = bot;
    return r;
  endfunction

`ifdef MEDIAN_RANK_SELECT_EN
  function automatic pix9_t oet_even(input pix9_t p);
    pix9_t r;
    r = cs(p, 4'd0, 4'd1); r = cs(r, 4'd2, 4'd3); r = cs(r, 4'd4, 4'd5); r = cs(r, 4'd6, 4'd7);
    return r;
  endfunction

  function automatic pix9_t oet_odd(input pix9_t p);
    pix9_t r;
    r = cs(p, 4'd1, 4'd2); r = cs(r, 4'd3, 4'd4); r = cs(r, 4'd5, 4'd6); r = cs(r, 4'd7, 4'd8);
    return r;
  endfunction
`endif

  function automatic pix9_t stage_a(input pix9_t p);
    pix9_t r;
`ifdef MEDIAN_RANK_SELECT_EN
    r = oet_odd(oet_even(p));
    r = oet_even(r);
`else
    r = cs(p, 4'd1, 4'd2); r = cs(r, 4'd4, 4'd5); r = cs(r, 4'd7, 4'd8);
    r = cs(r, 4'd0, 4'd1); r = cs(r, 4'd3, 4'd4); r = cs(r, 4'd6, 4'd7);
`endif
    return r;
  endfunction

  function automatic pix9_t stage_b(input pix9_t p);
    pix9_t r;
`ifdef MEDIAN_RANK_SELECT_EN
    r = oet_even(oet_odd(p));
`else
    r = cs(p, 4'd1, 4'd2); r = cs(r, 4'd4, 4'd5); r = cs(r, 4'd7, 4'd8);
    r = cs(r, 4'd0, 4'd3); r = cs(r, 4'd5, 4'd8); r = cs(r, 4'd4, 4'd7);
`endif
    return r;
  endfunction

`ifdef MEDIAN_RANK_SELECT_EN
  function automatic pix9_t stage_c(input pix9_t p);
    return oet_even(oet_odd(p));
  endfunction

  function automatic logic [DATA_W-1:0] rank_out(input pix9_t p, input logic [1:0] rk);
    pix9_t r;
    logic [DATA_W-1:0] v;
    r = oet_even(oet_odd(p));
    case (rk)
      2'd1:    v = r[0];
      2'd2:    v = r[8];
      default: v = r[4];
    endcase
    return v;
  endfunction
`else
  function automatic logic [DATA_W-1:0] med_out(input pix9_t p);
    pix9_t r;
    r = cs(p, 4'd3, 4'd6); r = cs(r, 4'd1, 4'd4); r = cs(r, 4'd2, 4'd5);
    r = cs(r, 4'd4, 4'd7); r = cs(r, 4'd4, 4'd2); r = cs(r, 4'd6, 4'd4);
    r = cs(r, 4'd4, 4'd2);
    return r[4];
  endfunction
`endif

  state_t            state_q, state_d;
  logic [WID_W-1:0]  wid_q, wid_d, col_q, col_d;
  logic [LEN_W-1:0]  len_q, len_d, row_q, row_d;
  pix9_t             win_q, win_d, s1_q, s1_d, s2_q, s2_d;
  logic              win_v_q, win_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, net_out_s;
  logic              out_valid_q, out_valid_d, done_q, done_d;
  logic [DATA_W-1:0] lb0_mem [DEPTH];
  logic [DATA_W-1:0] lb1_mem [DEPTH];
  logic [DATA_W-1:0] lb0_rd_s, lb1_rd_s;
  logic              adv_s, accept_s, col_last_s, row_last_s, pipe_empty_s;
`ifdef MEDIAN_RANK_SELECT_EN
  pix9_t             s3_q, s3_d;
  logic              s3_v_q, s3_v_d;
  logic [1:0]        rank_q, rank_d;
  assign pipe_empty_s = !win_v_q && !s1_v_q && !s2_v_q && !s3_v_q && !out_valid_q;
`else
  assign pipe_empty_s = !win_v_q && !s1_v_q && !s2_v_q && !out_valid_q;
`endif

  assign adv_s      = !out_valid_q || out_ready;
  assign in_ready   = ((state_q == S_FILL) || (state_q == S_RUN)) && adv_s;
  assign accept_s   = in_valid && in_ready;
  assign lb0_rd_s   = lb0_mem[col_q];
  assign lb1_rd_s   = lb1_mem[col_q];
  assign col_last_s = (col_q == wid_q - WID_W'(1));
  assign row_last_s = (row_q == len_q - LEN_W'(1));
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign s          = state_q;

  // Frame control: state, latched geometry and raster counters.
  always_comb begin
    state_d = state_q;
    wid_d   = wid_q;
    len_d   = len_q;
`ifdef MEDIAN_RANK_SELECT_EN
    rank_d  = rank_q;
`endif
    if (accept_s) begin
      col_d = col_last_s ? WID_W'(0) : col_q + WID_W'(1);
      row_d = col_last_s ? row_q + LEN_W'(1) : row_q;
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && (wid >= WID_W'(3)) && (len >= LEN_W'(3))) begin
          state_d = S_FILL;
          wid_d   = wid;
          len_d   = len;
          col_d   = WID_W'(0);
          row_d   = LEN_W'(0);
`ifdef MEDIAN_RANK_SELECT_EN
          rank_d  = rank;
`endif
        end else if (start) begin
          state_d = S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_FILL:  state_d = (accept_s && col_last_s && (row_q == LEN_W'(1))) ? S_RUN : S_FILL;
      S_RUN:   state_d = (accept_s && col_last_s && row_last_s) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = pipe_empty_s ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  // Datapath: window capture and compare stages, all gated by adv.
  always_comb begin
    win_d       = win_q;
    win_v_d     = win_v_q;
    s1_d        = s1_q;
    s1_v_d      = s1_v_q;
    s2_d        = s2_q;
    s2_v_d      = s2_v_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MEDIAN_RANK_SELECT_EN
    s3_d        = s3_q;
    s3_v_d      = s3_v_q;
    net_out_s   = rank_out(s3_q, rank_q);
`else
    net_out_s   = med_out(s2_q);
`endif
    if (adv_s) begin
      win_v_d = accept_s && (row_q >= LEN_W'(2)) && (col_q >= WID_W'(2));
      win_d   = accept_s ? shift_in(win_q, lb1_rd_s, lb0_rd_s, in_data) : win_q;
      s1_v_d  = win_v_q;
      s1_d    = stage_a(win_q);
      s2_v_d  = s1_v_q;
      s2_d    = stage_b(s1_q);
`ifdef MEDIAN_RANK_SELECT_EN
      s3_v_d      = s2_v_q;
      s3_d        = stage_c(s2_q);
      out_valid_d = s3_v_q;
`else
      out_valid_d = s2_v_q;
`endif
      out_data_d  = net_out_s;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Line buffers: read-before-write at the current column, no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_mem[col_q] <= lb0_rd_s;
      lb0_mem[col_q] <= in_data;
    end
  end

  // Pixel data registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    s1_q  <= s1_d;
    s2_q  <= s2_d;
`ifdef MEDIAN_RANK_SELECT_EN
    s3_q  <= s3_d;
`endif
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wid_q       <= WID_W'(0);
      len_q       <= LEN_W'(0);
      col_q       <= WID_W'(0);
      row_q       <= LEN_W'(0);
      win_v_q     <= 1'b0;
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_data_q  <= DATA_W'(0);
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEDIAN_RANK_SELECT_EN
      s3_v_q      <= 1'b0;
      rank_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      wid_q       <= wid_d;
      len_q       <= len_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_v_q     <= win_v_d;
      s1_v_q      <= s1_v_d;
      s2_v_q      <= s2_v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef MEDIAN_RANK_SELECT_EN
      s3_v_q      <= s3_v_d;
      rank_q      <= rank_d;
`endif
    end
  end

endmodule
